pipelined_carry_lookahead_adder: RTL and testbench



---
 rtl/pipelined_carry_lookahead_adder_pkg.sv | 7 +
 rtl/pipelined_carry_lookahead_adder_cla_block.sv | 30 +++
 rtl/pipelined_carry_lookahead_adder.sv | 66 ++++++
 tb/tb_pipelined_carry_lookahead_adder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pipelined_carry_lookahead_adder_pkg.sv
// pipelined_carry_lookahead_adder_pkg: shared latency constant and block-count helper
package pipelined_carry_lookahead_adder_pkg;
  localparam int ADDER_LATENCY = 3;
  function automatic int num_blocks(input int width, input int group);
    return (width + group - 1) / group;
  endfunction
endpackage

// File: rtl/pipelined_carry_lookahead_adder_cla_block.sv
// cla_block: combinational N-bit lookahead unit producing per-bit carries and block G/P
module cla_block #(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         cin,
  output logic [N-1:0] c,
  output logic         bg,
  output logic         bp
);
  // Flat sum-of-products carry into bit i: cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1]
  function automatic logic carry_at(input int i, input logic [N-1:0] gg, input logic [N-1:0] pp, input logic ci);
    logic acc, t;
    acc = ci;
    for (int k = 0; k < i; k++) acc = acc & pp[k];
    for (int j = 0; j < i; j++) begin
      t = gg[j];
      for (int k = j + 1; k < i; k++) t = t & pp[k];
      acc = acc | t;
    end
    return acc;
  endfunction
  always_comb begin
    c = '0;
    for (int i = 0; i < N; i++) c[i] = carry_at(i, g, p, cin);
    bg = carry_at(N, g, p, 1'b0);
    bp = &p;
  end
endmodule

// File: rtl/pipelined_carry_lookahead_adder.sv
// pipelined_carry_lookahead_adder: registered-input lookahead adder with a 3-cycle sample-to-result latency
module pipelined_carry_lookahead_adder
  import pipelined_carry_lookahead_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);
  localparam int NB = num_blocks(WIDTH, GROUP);
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, g_d, g_q, p_d, p_q, sp_d, sp_q, ic;
  logic [WIDTH:0]   c_d, c_q, result_d, result_q;
  logic [NB-1:0]    blk_g, blk_p;
  logic [NB:0]      bc;
  genvar k;
  for (k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * GROUP;
    localparam int BW = (WIDTH - LO < GROUP) ? WIDTH - LO : GROUP;
    cla_block #(.N(BW)) u_cla (
      .g  (g_q[LO +: BW]),
      .p  (p_q[LO +: BW]),
      .cin(bc[k]),
      .c  (ic[LO +: BW]),
      .bg (blk_g[k]),
      .bp (blk_p[k])
    );
  end
  // Block G/P never depend on cin, so this chain feeds the blocks without a loop
  always_comb begin
    bc = '0;
    for (int j = 0; j < NB; j++) bc[j+1] = blk_g[j] | (blk_p[j] & bc[j]);
  end
  always_comb begin
    a_d = i_add1;
    b_d = i_add2;
    g_d = a_q & b_q;
    p_d = a_q ^ b_q;
    c_d = {bc[NB], ic};
    sp_d = p_q;
    result_d = {c_q[WIDTH], sp_q ^ c_q[WIDTH-1:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      g_q <= '0;
      p_q <= '0;
      c_q <= '0;
      sp_q <= '0;
      result_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      g_q <= g_d;
      p_q <= p_d;
      c_q <= c_d;
      sp_q <= sp_d;
      result_q <= result_d;
    end
  end
  assign o_result = result_q;
endmodule

// File: tb/tb_pipelined_carry_lookahead_adder.sv
// tb_pipelined_carry_lookahead_adder: directed and random checks against a delayed golden sum
module tb_pipelined_carry_lookahead_adder;
  import pipelined_carry_lookahead_adder_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic run = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [8:0] o8;
  logic [12:0] a13 = '0, b13 = '0;
  logic [13:0] o13;
  logic [8:0] q8[$];
  logic [13:0] q13[$];
  int errors = 0, checks = 0;
  logic [7:0] sa[4] = '{8'd1, 8'd2, 8'd100, 8'd255};
  logic [7:0] sb[4] = '{8'd1, 8'd2, 8'd200, 8'd255};
  logic [13:0] sx[4] = '{14'd2, 14'd4, 14'd300, 14'd510};

  pipelined_carry_lookahead_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
    .clk(clk), .rst(rst), .i_add1(a8), .i_add2(b8), .o_result(o8));
  pipelined_carry_lookahead_adder #(.WIDTH(13), .GROUP(4)) u_dut13 (
    .clk(clk), .rst(rst), .i_add1(a13), .i_add2(b13), .o_result(o13));

  always #5 clk = ~clk;

  // Golden model: the arithmetic sum of each sampled pair, seen ADDER_LATENCY edges later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q8.delete();
      q13.delete();
    end else begin
      q8.push_back({1'b0, a8} + {1'b0, b8});
      q13.push_back({1'b0, a13} + {1'b0, b13});
      while (q8.size() > ADDER_LATENCY + 1) void'(q8.pop_front());
      while (q13.size() > ADDER_LATENCY + 1) void'(q13.pop_front());
    end
  end

  task automatic chk(input string n, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_w8", 14'(o8), 14'(q8.size() > ADDER_LATENCY ? q8[0] : 9'd0));
      chk("model_w13", o13, q13.size() > ADDER_LATENCY ? q13[0] : 14'd0);
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    a8 = a;
    b8 = b;
    a13 = 13'($urandom);
    b13 = 13'($urandom);
  endtask

  task automatic hold(input string n, input logic [7:0] a, input logic [7:0] b, input logic [13:0] exp);
    @(negedge clk);
    drive(a, b);
    repeat (11) @(negedge clk);
    chk(n, 14'(o8), exp);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    chk("reset", 14'(o8), 14'd0);
    chk("reset_w13", o13, 14'd0);
    drive(8'd10, 8'd7);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("latency", 14'(o8), i < 4 ? 14'd0 : 14'd17);
    end
    repeat (7) @(negedge clk);
    chk("hold_17", 14'(o8), 14'd17);
    hold("sum_51", 8'd20, 8'd31, 14'd51);
    hold("sum_28", 8'd5, 8'd23, 14'd28);
    hold("sum_179", 8'd107, 8'd72, 14'd179);
    hold("max_510", 8'd255, 8'd255, 14'd510);
    hold("cout_256", 8'd255, 8'd1, 14'd256);
    hold("zero", 8'd0, 8'd0, 14'd0);
    hold("block_16", 8'h0f, 8'h01, 14'd16);
    @(negedge clk);
    a13 = 13'h1fff;
    b13 = 13'h1fff;
    repeat (5) @(negedge clk);
    chk("w13_max", o13, 14'd16382);
    a13 = 13'h0fff;
    b13 = 13'h0001;
    repeat (5) @(negedge clk);
    chk("w13_short_blk", o13, 14'd4096);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 4) chk("stream", 14'(o8), sx[i-4]);
      if (i < 4) drive(sa[i], sb[i]);
      else drive(8'd0, 8'd0);
    end
    @(negedge clk) drive(8'd1, 8'd2);
    @(negedge clk) drive(8'd3, 8'd4);
    @(negedge clk) drive(8'd5, 8'd6);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 14'(o8), 14'd0);
    chk("async_rst_w13", o13, 14'd0);
    drive(8'd9, 8'd9);
    @(posedge clk);
    #6 rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("post_rst", 14'(o8), i < 4 ? 14'd0 : 14'd18);
    end
    repeat (1000) begin
      @(negedge clk);
      drive(8'($urandom), 8'($urandom));
    end
    repeat (5) @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
